stage_fetch: RTL
================

# stage_fetch

Instruction fetch stage of the five-stage pipeline. Keeps the program counter and issues single-outstanding requests to instruction memory. Presents instruction/PC pairs to the decode stage, holding them stable while decode stalls, and redirects on taken branches and jumps. A one-entry skid buffer absorbs a memory response that arrives while decode is stalled.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset
- PC_STEP, 4, sequential PC increment in bytes

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- imem_req_o  out  1  single-cycle request pulse to instruction memory
- imem_addr_o  out  INSTR_SIZE  request address; valid while imem_req_o=1
- imem_rvalid_i  in  1  response strobe, ≥1 cycle after request
- imem_rdata_i  in  INSTR_SIZE  response instruction, valid with imem_rvalid_i
- stall_i  in  1  decode stall; output instruction not consumed this cycle
- redirect_i  in  1  taken branch/jump
- redirect_pc_i  in  INSTR_SIZE  redirect target
- pc_o  out  INSTR_SIZE  PC of instr_o
- instr_o  out  INSTR_SIZE  instruction to decode
- instr_valid_o  out  1  instr_o valid

## Operation
- Registers: pc_q (next fetch address), req_pc_q (address in flight), output reg {instr_o, pc_o, instr_valid_o}, skid {skid_instr, skid_pc}, state.
- Consume: output reg drains in any cycle with instr_valid_o=1 and stall_i=0. Output is "free" if instr_valid_o=0 or it drains this cycle.
- imem_req_o = (state==IDLE); imem_addr_o = pc_q.
- States:
  - BOOT: entered on reset; no request. Next: IDLE.
  - IDLE: request issued. req_pc_q<=pc_q, pc_q<=pc_q+PC_STEP. Next: WAIT, or KILL if redirect_i.
  - WAIT: one request outstanding. On rvalid with output free: output<=rdata/req_pc_q, valid=1, go IDLE. On rvalid with output not free: skid<=rdata/req_pc_q, go HOLD.
  - HOLD: skid full, no request. When output drains: output<=skid, go IDLE.
  - KILL: an outstanding response is to be discarded. On rvalid: drop it, go IDLE.
- Redirect (highest priority, any state except BOOT):
  - instr_valid_o<=0 and skid cleared next cycle.
  - pc_q<=redirect_pc_i, overriding the increment.
  - Next state: KILL if a request is outstanding and rvalid is not present this cycle (WAIT, or IDLE issuing). Otherwise IDLE.
  - Redirect during KILL: pc_q updated, stay KILL.
- rvalid in BOOT, IDLE or HOLD is a protocol error. It is ignored and must not corrupt state.
- PC arithmetic is modulo 2^INSTR_SIZE; wrap-around is silent.
- Drained output with no new data: instr_valid_o<=0; instr_o/pc_o keep their last value.

## Timing
- Reset values: imem_req_o=0, imem_addr_o=RESET_PC, pc_o=0, instr_o=0 (NOP_INSTR encoding all-zero), instr_valid_o=0, state=BOOT, skid empty.
- First request: cycle 1 after reset_n rises, address RESET_PC.
- Latency: rvalid at cycle t produces instr_valid_o at t+1 (output free). Next request is issued at t+1.
- Throughput: one instruction per (memory latency + 1) cycles.
- Stall: instr_o/pc_o/instr_valid_o are held bit-stable for every cycle stall_i=1.
- Reset mid-operation: all state returns to reset values next edge. An in-flight response is ignored via BOOT.

## Structure
- PARAMS_pkg additions: fetch_state_t enum {FS_BOOT, FS_IDLE, FS_WAIT, FS_KILL, FS_HOLD}, PC_STEP constant, RESET_PC default constant. INSTR_SIZE and NOP_INSTR come from the same package.
- One natural sub-module: fetch_skid_buf (1-entry instr+PC buffer with load/drain/flush).

## Test plan
- Reset, 1-cycle memory, stall_i=0 → requests at 0x0, 0x4, 0x8 on cycles 1, 3, 5; instr_valid_o with pc_o=0x0, 0x4, 0x8 on cycles 3, 5, 7.
- stall_i=1 for 6 cycles after first instruction → instr_o held. Second response captured into skid, state HOLD, imem_req_o=0. On release, pc_o=0x4 the next cycle, then request 0x8.
- redirect_i to 0x100 while WAIT (3-cycle memory) → instr_valid_o=0 next cycle, late response dropped, next request addr 0x100, and the following instruction's pc_o=0x100.
- redirect_i coincident with rvalid → response dropped, IDLE, request 0x200 on next cycle; no KILL entered.
- RESET_PC=32'hFFFF_FFFC → second request address 32'h0000_0000.
- reset_n low during HOLD with pending rvalid → all outputs at reset values next cycle; the stray rvalid is ignored; first post-reset pc_o=RESET_PC.

Source files
------------

// File: rtl/stage_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package stage_fetch_pkg;

   localparam int unsigned INSTR_SIZE = 32;
   localparam logic [INSTR_SIZE-1:0] NOP_INSTR = '0;
   localparam int unsigned DEFAULT_PC_STEP = 4;
   localparam logic [INSTR_SIZE-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [2:0] {
      FS_BOOT,
      FS_IDLE,
      FS_WAIT,
      FS_KILL,
      FS_HOLD
   } fetch_state_t;

endpackage

// File: rtl/stage_fetch_if.sv
// Instruction memory request/response bus; master is the fetch stage.
interface stage_fetch_if;
   import stage_fetch_pkg::*;

   logic                  imem_req_o;
   logic [INSTR_SIZE-1:0] imem_addr_o;
   logic                  imem_rvalid_i;
   logic [INSTR_SIZE-1:0] imem_rdata_i;

   modport master (
      output imem_req_o,
      output imem_addr_o,
      input  imem_rvalid_i,
      input  imem_rdata_i
   );

   modport slave (
      input  imem_req_o,
      input  imem_addr_o,
      output imem_rvalid_i,
      output imem_rdata_i
   );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry instruction/PC holding buffer; flush wins over load.
module fetch_skid_buf
   import stage_fetch_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  load_i,
   input  logic                  flush_i,
   input  logic [INSTR_SIZE-1:0] instr_i,
   input  logic [INSTR_SIZE-1:0] pc_i,
   output logic [INSTR_SIZE-1:0] instr_o,
   output logic [INSTR_SIZE-1:0] pc_o,
   output logic                  full_o
);

   logic [INSTR_SIZE-1:0] instr_q;
   logic [INSTR_SIZE-1:0] pc_q;
   logic                  full_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         instr_q <= NOP_INSTR;
         pc_q    <= '0;
         full_q  <= 1'b0;
      end else if (flush_i) begin
         full_q <= 1'b0;
      end else if (load_i) begin
         instr_q <= instr_i;
         pc_q    <= pc_i;
         full_q  <= 1'b1;
      end
   end

   assign instr_o = instr_q;
   assign pc_o    = pc_q;
   assign full_o  = full_q;

endmodule

// File: rtl/stage_fetch.sv
// Fetch stage: single-outstanding imem requests, stall-stable output register,
// redirect handling and a one-entry skid for responses that land during a stall.
module stage_fetch
   import stage_fetch_pkg::*;
#(
   parameter logic [INSTR_SIZE-1:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int unsigned           PC_STEP  = DEFAULT_PC_STEP
) (
   input  logic                  clk,
   input  logic                  reset_n,
   stage_fetch_if.master         imem,
   input  logic                  stall_i,
   input  logic                  redirect_i,
   input  logic [INSTR_SIZE-1:0] redirect_pc_i,
   output logic [INSTR_SIZE-1:0] pc_o,
   output logic [INSTR_SIZE-1:0] instr_o,
   output logic                  instr_valid_o
);

   fetch_state_t          state_q;
   logic [INSTR_SIZE-1:0] pc_q;
   logic [INSTR_SIZE-1:0] req_pc_q;
   logic [INSTR_SIZE-1:0] out_instr_q;
   logic [INSTR_SIZE-1:0] out_pc_q;
   logic                  out_valid_q;

   logic                  out_drain;
   logic                  out_free;
   logic                  redir_act;
   logic                  skid_load;
   logic                  skid_flush;
   logic                  skid_full;
   logic [INSTR_SIZE-1:0] skid_instr;
   logic [INSTR_SIZE-1:0] skid_pc;

   assign out_drain  = out_valid_q && !stall_i;
   assign out_free   = !out_valid_q || !stall_i;
   assign redir_act  = redirect_i && (state_q != FS_BOOT);
   assign skid_load  = (state_q == FS_WAIT) && imem.imem_rvalid_i && !out_free && !redir_act;
   assign skid_flush = redir_act || ((state_q == FS_HOLD) && out_drain);

   fetch_skid_buf u_skid (
      .clk     (clk),
      .reset_n (reset_n),
      .load_i  (skid_load),
      .flush_i (skid_flush),
      .instr_i (imem.imem_rdata_i),
      .pc_i    (req_pc_q),
      .instr_o (skid_instr),
      .pc_o    (skid_pc),
      .full_o  (skid_full)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= FS_BOOT;
         pc_q        <= RESET_PC;
         req_pc_q    <= RESET_PC;
         out_instr_q <= NOP_INSTR;
         out_pc_q    <= '0;
         out_valid_q <= 1'b0;
      end else begin
         if (out_drain) out_valid_q <= 1'b0;
         unique case (state_q)
            FS_BOOT: state_q <= FS_IDLE;
            FS_IDLE: begin
               req_pc_q <= pc_q;
               pc_q     <= pc_q + INSTR_SIZE'(PC_STEP);
               state_q  <= FS_WAIT;
            end
            FS_WAIT: begin
               if (imem.imem_rvalid_i && !redir_act) begin
                  if (out_free) begin
                     out_instr_q <= imem.imem_rdata_i;
                     out_pc_q    <= req_pc_q;
                     out_valid_q <= 1'b1;
                     state_q     <= FS_IDLE;
                  end else begin
                     state_q <= FS_HOLD;
                  end
               end
            end
            FS_HOLD: begin
               if (out_drain && skid_full && !redir_act) begin
                  out_instr_q <= skid_instr;
                  out_pc_q    <= skid_pc;
                  out_valid_q <= 1'b1;
                  state_q     <= FS_IDLE;
               end
            end
            FS_KILL: if (imem.imem_rvalid_i) state_q <= FS_IDLE;
            default: state_q <= FS_BOOT;
         endcase
         // Redirect overrides everything above; KILL only if a response is still owed.
         if (redir_act) begin
            out_valid_q <= 1'b0;
            pc_q        <= redirect_pc_i;
            unique case (state_q)
               FS_IDLE:          state_q <= FS_KILL;
               FS_WAIT, FS_KILL: state_q <= imem.imem_rvalid_i ? FS_IDLE : FS_KILL;
               default:          state_q <= FS_IDLE;
            endcase
         end
      end
   end

   assign imem.imem_req_o  = (state_q == FS_IDLE);
   assign imem.imem_addr_o = pc_q;
   assign pc_o             = out_pc_q;
   assign instr_o          = out_instr_q;
   assign instr_valid_o    = out_valid_q;

endmodule
